// File: rtl/seq_mag_comp_pkg.sv
// Shared types and elaboration helpers for the sequential magnitude comparator.
package seq_mag_comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Exactly one of lt/eq/gt is set once a compare has completed.
  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } result_t;

  localparam result_t RES_NONE = '{lt: 1'b0, eq: 1'b0, gt: 1'b0};
  localparam result_t RES_EQ   = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};

  // Width of the digit counter, which must be able to hold the value ndig.
  function automatic int cnt_width(input int ndig);
    return (ndig < 1) ? 1 : $clog2(ndig + 1);
  endfunction

  function automatic bit params_ok(input int width, input int digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/seq_mag_comp_digit_cmp.sv
// Combinational DIGIT-bit unsigned comparator used once per cycle in RUN.
module digit_cmp #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             dlt,
  output logic             dgt
);

  assign dlt = (x < y);
  assign dgt = (x > y);

endmodule

// File: rtl/seq_mag_comp.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle.
// Define SEQ_MAG_COMP_SIGNED_EN to add the sgn input for two's-complement compares.
module seq_mag_comp
  import seq_mag_comp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 2,
  parameter int EARLY_EXIT = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [WIDTH-1:0]                       a,
  input  logic [WIDTH-1:0]                       b,
`ifdef SEQ_MAG_COMP_SIGNED_EN
  input  logic                                   sgn,
`endif
  output logic                                   busy,
  output logic                                   done,
  output logic                                   lt,
  output logic                                   eq,
  output logic                                   gt,
  output logic [cnt_width(WIDTH/DIGIT)-1:0]      cycles
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam bit EE   = (EARLY_EXIT != 0);

  generate
    if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
      $error("seq_mag_comp: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  // Handshake: a start seen in IDLE is accepted at that edge and busy rises;
  // busy stays high through RUN and DONE, done pulses for the single DONE
  // cycle, and starts seen while busy are dropped rather than queued.

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    idx;
  logic             diff_seen;
  result_t          diff_res;
  result_t          res;

  logic [WIDTH-1:0] load_a;
  logic [WIDTH-1:0] load_b;
  logic             dlt;
  logic             dgt;
  logic             dig_diff;
  logic             last_digit;
  result_t          dig_res;
  result_t          final_res;

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  always_comb begin
    load_a = a;
    load_b = b;
`ifdef SEQ_MAG_COMP_SIGNED_EN
    if (sgn) begin
      load_a[WIDTH-1] = ~a[WIDTH-1];
      load_b[WIDTH-1] = ~b[WIDTH-1];
    end
`endif
  end

  digit_cmp #(
    .DIGIT (DIGIT)
  ) u_digit_cmp (
    .x   (sa[WIDTH-1 -: DIGIT]),
    .y   (sb[WIDTH-1 -: DIGIT]),
    .dlt (dlt),
    .dgt (dgt)
  );

  assign dig_diff   = dlt | dgt;
  assign last_digit = (idx == CW'(NDIG - 1));
  assign dig_res    = '{lt: dlt, eq: 1'b0, gt: dgt};

  // The earliest differing digit decides; with early exit diff_seen never sets.
  always_comb begin
    final_res = RES_EQ;
    if (diff_seen) begin
      final_res = diff_res;
    end else if (dig_diff) begin
      final_res = dig_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      res       <= RES_NONE;
      cycles    <= '0;
      sa        <= '0;
      sb        <= '0;
      idx       <= '0;
      diff_seen <= 1'b0;
      diff_res  <= RES_NONE;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa        <= load_a;
            sb        <= load_b;
            idx       <= '0;
            diff_seen <= 1'b0;
            diff_res  <= RES_NONE;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          sa  <= sa << DIGIT;
          sb  <= sb << DIGIT;
          idx <= idx + CW'(1);
          if (last_digit || (EE && dig_diff)) begin
            // idx+1 equals NDIG on the last digit, so one expression covers both exits.
            res    <= final_res;
            cycles <= idx + CW'(1);
            done   <= 1'b1;
            state  <= DONE;
          end else if (dig_diff && !diff_seen) begin
            diff_seen <= 1'b1;
            diff_res  <= dig_res;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign lt = res.lt;
  assign eq = res.eq;
  assign gt = res.gt;

endmodule

// File: tb/tb_seq_mag_comp.sv
// Directed bench for seq_mag_comp: one early-exit and one constant-latency instance.
module tb_seq_mag_comp;

  localparam int NDIG = 4;
  localparam int CW   = 3;
  localparam logic [2:0] R_LT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_GT = 3'b001;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a     = '0;
  logic [7:0] b     = '0;
`ifdef SEQ_MAG_COMP_SIGNED_EN
  logic       sgn   = 1'b0;
`endif

  logic          busy1, done1, lt1, eq1, gt1;
  logic [CW-1:0] cycles1;
  logic          busy0, done0, lt0, eq0, gt0;
  logic [CW-1:0] cycles0;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [5:0] exp_q[$];
  logic [5:0] mon_e;
  logic [2:0] prev_res;

  // ---------------- clock / DUTs ----------------
  always #5 clk = ~clk;

  seq_mag_comp #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) dut_ee1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
`ifdef SEQ_MAG_COMP_SIGNED_EN
    .sgn    (sgn),
`endif
    .busy   (busy1),
    .done   (done1),
    .lt     (lt1),
    .eq     (eq1),
    .gt     (gt1),
    .cycles (cycles1)
  );

  seq_mag_comp #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)) dut_ee0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
`ifdef SEQ_MAG_COMP_SIGNED_EN
    .sgn    (sgn),
`endif
    .busy   (busy0),
    .done   (done0),
    .lt     (lt0),
    .eq     (eq0),
    .gt     (gt0),
    .cycles (cycles0)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard for the early-exit instance: every done pulse must match a queued result.
  always @(negedge clk) begin
    if (rst_n && done1) begin
      check("done_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("ee1_result", {26'd0, lt1, eq1, gt1, cycles1}, {26'd0, mon_e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns on the negedge where both instances have shown done, so the next
  // call's start lands in the IDLE cycle right after DONE (back-to-back).
  task automatic run_cmp(input logic [7:0] av, input logic [7:0] bv, input logic sg,
                         input logic [2:0] er, input int c1, input bit mid_start);
    int lat1 = 0;
    int lat0 = 0;
    int n1   = 0;
    @(negedge clk);
    a = av;
    b = bv;
`ifdef SEQ_MAG_COMP_SIGNED_EN
    sgn = sg;
`else
    if (sg) $display("note: sgn request ignored in unsigned build");
`endif
    start = 1'b1;
    exp_q.push_back({er, 3'(c1)});
    @(negedge clk);
    start = 1'b0;
    check("busy_ee1", {31'd0, busy1}, 32'd1);
    check("busy_ee0", {31'd0, busy0}, 32'd1);
    check("flags_hold", {29'd0, lt1, eq1, gt1}, {29'd0, prev_res});
    for (int k = 1; k <= NDIG + 4; k++) begin
      @(negedge clk);
      if (mid_start) begin
        if (k == 1) begin
          start = 1'b1;
          a     = 8'h00;
          b     = 8'hFF;
        end else if (k == 2) begin
          start = 1'b0;
        end
      end
      if (done1) begin
        n1++;
        if (lat1 == 0) lat1 = k;
      end
      if (done0 && lat0 == 0) begin
        lat0 = k;
        check("ee0_result", {26'd0, lt0, eq0, gt0, cycles0}, {26'd0, er, 3'(NDIG)});
      end
      if (!mid_start && lat1 != 0 && lat0 != 0) break;
    end
    check("latency_ee1", lat1, c1);
    check("latency_ee0", lat0, NDIG);
    if (mid_start) check("done_pulses", n1, 1);
    prev_res = er;
  endtask

  task automatic mid_reset();
    int seen = 0;
    @(negedge clk);
    a     = 8'h12;
    b     = 8'h13;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_reset_busy", {31'd0, busy1}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy",   {30'd0, busy1, busy0}, 32'd0);
    check("rst_done",   {30'd0, done1, done0}, 32'd0);
    check("rst_flags",  {26'd0, lt1, eq1, gt1, lt0, eq0, gt0}, 32'd0);
    check("rst_cycles", {26'd0, cycles1, cycles0}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      if (done1 || done0) seen++;
    end
    check("rst_no_done", seen, 0);
    rst_n    = 1'b1;
    prev_res = 3'b000;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    prev_res = 3'b000;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy_done", {28'd0, busy1, done1, busy0, done0}, 32'd0);
    check("reset_flags", {26'd0, lt1, eq1, gt1, lt0, eq0, gt0}, 32'd0);
    check("reset_cycles", {26'd0, cycles1, cycles0}, 32'd0);
    rst_n = 1'b1;

    run_cmp(8'hA5, 8'hA5, 1'b0, R_EQ, 4, 1'b0);
    run_cmp(8'h80, 8'h7F, 1'b0, R_GT, 1, 1'b0);
    run_cmp(8'h12, 8'h13, 1'b0, R_LT, 4, 1'b0);
    run_cmp(8'h40, 8'h3F, 1'b0, R_GT, 1, 1'b0);
    run_cmp(8'hA5, 8'hA5, 1'b0, R_EQ, 4, 1'b1);
    run_cmp(8'hC4, 8'hC8, 1'b0, R_LT, 3, 1'b0);
    run_cmp(8'hFF, 8'hFE, 1'b0, R_GT, 4, 1'b0);
    run_cmp(8'h00, 8'hFF, 1'b0, R_LT, 1, 1'b0);
    mid_reset();
    run_cmp(8'h12, 8'h13, 1'b0, R_LT, 4, 1'b0);
`ifdef SEQ_MAG_COMP_SIGNED_EN
    run_cmp(8'hFF, 8'h01, 1'b1, R_LT, 1, 1'b0);
    run_cmp(8'hFF, 8'h01, 1'b0, R_GT, 1, 1'b0);
    run_cmp(8'h80, 8'h7F, 1'b1, R_LT, 1, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check("idle_at_end", {30'd0, busy1, busy0}, 32'd0);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
